fp_addsub_pipe: RTL and testbench



---
 rtl/fp_addsub_pkg.sv | 21 ++
 rtl/fp_addsub_if.sv | 33 +++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_addsub_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types, flag positions and special-value patterns for the pipelined FP add/sub unit.
package fp_addsub_pkg;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

  localparam int unsigned FlagW         = 4;
  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  // Patterns are right-aligned in 64 bits; callers truncate to 1+ew+mw.
  function automatic logic [63:0] fp_qnan(int unsigned ew, int unsigned mw);
    return (((64'(1) << ew) - 64'(1)) << mw) | (64'(1) << (mw - 1));
  endfunction

  function automatic logic [63:0] fp_inf(int unsigned ew, int unsigned mw);
    return ((64'(1) << ew) - 64'(1)) << mw;
  endfunction

endpackage

// File: rtl/fp_addsub_if.sv
// Operand/result handshake bundle for fp_addsub_pipe; master is the producer/consumer side.
interface fp_addsub_if
  import fp_addsub_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_c;
  logic [FlagW-1:0] out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_a, in_b, in_sub, in_tag, in_valid, out_ready,
    input  in_ready, out_c, out_flags, out_tag, out_valid
  );

  modport slave (
    input  in_a, in_b, in_sub, in_tag, in_valid, out_ready,
    output in_ready, out_c, out_flags, out_tag, out_valid
  );

endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 27
) (
  input  logic [WIDTH-1:0]             in_i,
  output logic [$clog2(WIDTH+1)-1:0]   cnt_o
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Ascending scan so the most significant set bit is the last to write.
  always_comb begin
    cnt_o = CntW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt_o = CntW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage IEEE-754 add/subtract with RNE rounding, gradual underflow and elastic stalls.
module fp_addsub_pipe
  import fp_addsub_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  fp_addsub_if.slave bus
);
  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned SW  = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned LzW = $clog2(SW + 1);
  localparam logic [W-1:0] QnanC = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0] InfC  = W'(fp_inf(EXP_W, MAN_W));

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     c;
    logic [FlagW-1:0] f;
    logic             zsign;
    logic [TAG_W-1:0] tag;
  } byp_t;

  typedef struct packed {
    byp_t             byp;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] diff;
    logic [MAN_W:0]   man_l;
    logic [MAN_W:0]   man_s;
  } s1_t;

  typedef struct packed {
    byp_t             byp;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
  } s2_t;

  typedef struct packed {
    byp_t             byp;
    logic             sign;
    logic             zero;
    logic [EXP_W:0]   exp;
    logic [SW-1:0]    norm;
  } s3_t;

  typedef struct packed {
    logic [W-1:0]     c;
    logic [FlagW-1:0] f;
    logic [TAG_W-1:0] tag;
  } s4_t;

  function automatic fp_class_e classify(logic [EXP_W-1:0] e, logic [MAN_W-1:0] f);
    fp_class_e cls;
    if (e == '0)      cls = (f == '0) ? ZERO : SUB;
    else if (e == '1) cls = (f == '0) ? INF : (f[MAN_W-1] ? QNAN : SNAN);
    else              cls = NORM;
    return cls;
  endfunction

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  logic v1_q, v2_q, v3_q, v4_q;
  logic ld1, ld2, ld3, ld4;

  // Each stage loads when it is empty or its content moves on this cycle.
  assign ld4 = !v4_q | bus.out_ready;
  assign ld3 = !v3_q | ld4;
  assign ld2 = !v2_q | ld3;
  assign ld1 = !v1_q | ld2;

  assign bus.in_ready  = ld1;
  assign bus.out_valid = v4_q;
  assign bus.out_c     = s4_q.c;
  assign bus.out_flags = s4_q.f;
  assign bus.out_tag   = s4_q.tag;

  // S1: unpack, classify, swap so the larger magnitude is first.
  logic             sa, sb_raw, sb, swap;
  logic [EXP_W-1:0] ea, eb, el, es;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  fp_class_e        cls_a, cls_b;

  assign {sa, ea, fa}     = bus.in_a;
  assign {sb_raw, eb, fb} = bus.in_b;
  assign sb               = sb_raw ^ bus.in_sub;

  always_comb begin
    cls_a = classify(ea, fa);
    cls_b = classify(eb, fb);
    swap  = {eb, fb} > {ea, fa};
    el    = swap ? eb : ea;
    es    = swap ? ea : eb;
    fl    = swap ? fb : fa;
    fs    = swap ? fa : fb;
    s1_d           = '0;
    s1_d.byp.tag   = bus.in_tag;
    s1_d.byp.zsign = sa & sb;
    s1_d.sign      = swap ? sb : sa;
    s1_d.eff_sub   = sa ^ sb;
    s1_d.exp       = (el == '0) ? EXP_W'(1) : el;
    s1_d.diff      = s1_d.exp - ((es == '0) ? EXP_W'(1) : es);
    s1_d.man_l     = {el != '0, fl};
    s1_d.man_s     = {es != '0, fs};
    if (cls_a inside {QNAN, SNAN} || cls_b inside {QNAN, SNAN}) begin
      s1_d.byp.spec           = 1'b1;
      s1_d.byp.c              = QnanC;
      s1_d.byp.f[FlagInvalid] = (cls_a == SNAN) | (cls_b == SNAN);
    end else if (cls_a == INF && cls_b == INF && sa != sb) begin
      s1_d.byp.spec           = 1'b1;
      s1_d.byp.c              = QnanC;
      s1_d.byp.f[FlagInvalid] = 1'b1;
    end else if (cls_a == INF) begin
      s1_d.byp.spec = 1'b1;
      s1_d.byp.c    = {sa, InfC[W-2:0]};
    end else if (cls_b == INF) begin
      s1_d.byp.spec = 1'b1;
      s1_d.byp.c    = {sb, InfC[W-2:0]};
    end
  end

  // S2: align the smaller operand; everything shifted out folds into the sticky bit.
  logic [31:0]     shamt;
  logic [2*SW-1:0] wide;
  logic [SW-1:0]   aligned;

  always_comb begin
    shamt   = (32'(s1_q.diff) > SW) ? SW : 32'(s1_q.diff);
    wide    = {s1_q.man_s, 3'b000, {SW{1'b0}}} >> shamt;
    aligned = wide[2*SW-1:SW] | SW'(|wide[SW-1:0]);
    s2_d      = '0;
    s2_d.byp  = s1_q.byp;
    s2_d.sign = s1_q.sign;
    s2_d.exp  = s1_q.exp;
    s2_d.sum  = s1_q.eff_sub ? {1'b0, s1_q.man_l, 3'b000} - {1'b0, aligned}
                             : {1'b0, s1_q.man_l, 3'b000} + {1'b0, aligned};
  end

  // S3: normalise, never shifting the exponent below 1 (gradual underflow).
  logic [LzW-1:0] lz;
  logic [31:0]    lim, lshift;

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .in_i  (s2_q.sum[SW-1:0]),
    .cnt_o (lz)
  );

  always_comb begin
    s3_d      = '0;
    s3_d.byp  = s2_q.byp;
    s3_d.sign = s2_q.sign;
    s3_d.zero = (s2_q.sum == '0);
    lim       = 32'(s2_q.exp) - 32'd1;
    lshift    = (32'(lz) > lim) ? lim : 32'(lz);
    if (s2_q.sum[SW]) begin
      s3_d.norm = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
      s3_d.exp  = {1'b0, s2_q.exp} + (EXP_W+1)'(1);
    end else begin
      s3_d.norm = s2_q.sum[SW-1:0] << lshift;
      s3_d.exp  = {1'b0, s2_q.exp} - (EXP_W+1)'(lshift);
      if (!s3_d.norm[SW-1]) s3_d.exp = '0;
    end
  end

  // S4: round to nearest even; a fraction carry ripples into the exponent field.
  logic                 rnd, inx, tiny, ovf;
  logic [EXP_W+MAN_W:0] mag;

  always_comb begin
    rnd  = s3_q.norm[2] & (s3_q.norm[1] | s3_q.norm[0] | s3_q.norm[3]);
    inx  = |s3_q.norm[2:0];
    tiny = !s3_q.norm[SW-1];
    mag  = {s3_q.exp, s3_q.norm[SW-2:3]} + (EXP_W+MAN_W+1)'(rnd);
    ovf  = mag[MAN_W +: EXP_W+1] >= {1'b0, {EXP_W{1'b1}}};
    s4_d     = '0;
    s4_d.tag = s3_q.byp.tag;
    if (s3_q.byp.spec) begin
      s4_d.c = s3_q.byp.c;
      s4_d.f = s3_q.byp.f;
    end else if (s3_q.zero) begin
      s4_d.c = {s3_q.byp.zsign, {(W-1){1'b0}}};
    end else if (ovf) begin
      s4_d.c                = {s3_q.sign, InfC[W-2:0]};
      s4_d.f[FlagOverflow]  = 1'b1;
      s4_d.f[FlagInexact]   = 1'b1;
    end else begin
      s4_d.c                = {s3_q.sign, mag[EXP_W+MAN_W-1:0]};
      s4_d.f[FlagInexact]   = inx;
      s4_d.f[FlagUnderflow] = tiny & inx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else begin
      if (ld1) begin
        v1_q <= bus.in_valid;
        s1_q <= s1_d;
      end
      if (ld2) begin
        v2_q <= v1_q;
        s2_q <= s2_d;
      end
      if (ld3) begin
        v3_q <= v2_q;
        s3_q <= s3_d;
      end
      if (ld4) begin
        v4_q <= v3_q;
        s4_q <= s4_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Vector table plus scoreboard for fp_addsub_pipe in its FP32 configuration.
module tb_fp_addsub_pipe;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned TW = 4;
  localparam int NV = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_if #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) bus ();

  fp_addsub_pipe #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] c;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic [3:0]  f;
    logic [3:0]  tag;
    int          cyc;
    int          id;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb_q[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nout  = 0;
  int   bp_base = 0;
  bit   chk_lat = 1'b0;
  bit   bp_on   = 1'b0;
  logic [31:0] held_c;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One clock: entered at negedge with inputs driven; samples, then advances to next negedge.
  task automatic tick(output bit acc);
    exp_t e;
    int   rel;
    rel = cyc - bp_base;
    if (bp_on) bus.out_ready = !(rel >= 5 && rel <= 8);
    #1;
    if (bp_on && rel == 5) begin
      check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
      held_c = bus.out_c;
    end
    if (bp_on && rel == 8) begin
      check("bp_hold_valid", 64'(bus.out_valid), 64'(1));
      check("bp_hold_c", 64'(bus.out_c), 64'(held_c));
    end
    if (bp_on && rel == 9) check("bp_in_ready_back", 64'(bus.in_ready), 64'(1));
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      e     = cur_exp;
      e.cyc = cyc;
      sb_q.push_back(e);
    end
    if (bus.out_valid && bus.out_ready) begin
      nout++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got tag %0h want none", bus.out_tag);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("c[%0d]", e.id), 64'(bus.out_c), 64'(e.c));
        check($sformatf("flags[%0d]", e.id), 64'(bus.out_flags), 64'(e.f));
        check($sformatf("tag[%0d]", e.id), 64'(bus.out_tag), 64'(e.tag));
        if (chk_lat) check($sformatf("lat[%0d]", e.id), 64'(cyc - e.cyc), 64'(4));
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(int id, logic [3:0] tag);
    bit acc;
    int w;
    bus.in_a     = vecs[id].a;
    bus.in_b     = vecs[id].b;
    bus.in_sub   = vecs[id].sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    cur_exp      = '{c: vecs[id].c, f: vecs[id].f, tag: tag, cyc: 0, id: id};
    w = 0;
    do begin
      tick(acc);
      w++;
    end while (!acc && w < 100);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout[%0d]: got no accept want accept", id);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      tick(acc);
      w++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit acc;
    // {a, b, sub, expected c, expected {invalid, overflow, underflow, inexact}}
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    vecs[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[7]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
    vecs[8]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    vecs[10] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    vecs[11] = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000};
    vecs[12] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
    vecs[13] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
    vecs[14] = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000};
    vecs[15] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    vecs[16] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    vecs[17] = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000};

    rst           = 1'b1;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_tag    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_c", 64'(bus.out_c), 64'(0));
    check("rst_out_flags", 64'(bus.out_flags), 64'(0));
    check("rst_out_tag", 64'(bus.out_tag), 64'(0));

    // Table: back-to-back issue, consumer always ready, fixed 4-cycle latency.
    chk_lat = 1'b1;
    for (int i = 0; i < NV; i++) send(i, 4'(i + 3));
    drain();
    chk_lat = 1'b0;

    // Back-pressure: 8 ops tagged 0..7, consumer stalls in relative cycles 5-8.
    n0      = nout;
    bp_base = cyc;
    bp_on   = 1'b1;
    for (int i = 0; i < 8; i++) send(i, 4'(i));
    drain();
    bp_on         = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_count", 64'(nout - n0), 64'(8));

    // Reset mid-stream discards everything in flight.
    for (int i = 0; i < 3; i++) send(i + 6, 4'(i + 9));
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("mid_rst_out_c", 64'(bus.out_c), 64'(0));
    check("mid_rst_out_tag", 64'(bus.out_tag), 64'(0));
    sb_q.delete();
    n0 = nout;
    repeat (10) tick(acc);
    check("mid_rst_no_stale", 64'(nout - n0), 64'(0));

    // Pipe must still work after the mid-stream reset.
    send(0, 4'hA);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
